// File: rtl/vmem_arbiter.sv
// vmem_arbiter
//   Single-port arbiter/sequencer for the 640x480x24 video memory, addressed
//   as {h[9:0], v[8:0]}. One RAM port is shared by, in priority order:
//     1. VGA scan-out reads (never stalled; 1-cycle read latency)
//     2. the frame-clear engine (sweeps the whole frame with one color)
//     3. a small write FIFO fed by drawing/keyboard logic
//
// Ports
//   clk, resetn                      clock, async active-low reset
//   disp_req, disp_h, disp_v         scan-out read request and address
//   disp_rvalid, disp_rdata          read data, one cycle after disp_req
//   wr_valid, wr_ready               pixel write handshake into the FIFO
//   wr_h, wr_v, wr_data              pixel write address and RGB
//   clear_start, clear_color         start a full-frame fill with a color
//   clear_busy                       fill in progress
//   drop_cnt                         saturating count of out-of-range writes
//   mem_en, mem_we, mem_addr,        RAM port, combinational from the
//   mem_wdata, mem_rdata             current-cycle grant

module vmem_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        disp_req,
  input  logic [9:0]  disp_h,
  input  logic [8:0]  disp_v,
  output logic        disp_rvalid,
  output logic [23:0] disp_rdata,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_h,
  input  logic [8:0]  wr_v,
  input  logic [23:0] wr_data,
  input  logic        clear_start,
  input  logic [23:0] clear_color,
  output logic        clear_busy,
  output logic [7:0]  drop_cnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam logic [9:0] H_LAST = 10'(H_PIX - 1);
  localparam logic [8:0] V_LAST = 9'(V_PIX - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [9:0]    clr_h;
  logic [8:0]    clr_v;
  logic [23:0]   clr_color;

  // Each FIFO entry is {h, v, rgb}.
  logic [42:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          clr_grant;
  logic          head_ok;
  logic [9:0]    head_h;
  logic [8:0]    head_v;
  logic [23:0]   head_d;

  assign {head_h, head_v, head_d} = fifo_mem[rd_ptr];

  // Depth is a power of two, so the count MSB alone marks full.
  assign full     = count[AW];
  assign empty    = (count == '0);
  assign wr_ready = resetn & ~full;
  assign push     = wr_valid & wr_ready;
  assign head_ok  = (head_h <= H_LAST) && (head_v <= V_LAST);

  assign disp_rdata = mem_rdata;
  assign clear_busy = (state == CLEAR);

  // Grant: scan-out read, then clear sweep, then FIFO drain.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    drop      = 1'b0;
    clr_grant = 1'b0;
    if (resetn) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = {disp_h, disp_v};
      end else if (state == CLEAR) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {clr_h, clr_v};
        mem_wdata = clr_color;
        clr_grant = 1'b1;
      end else if (!empty) begin
        pop = 1'b1;
        if (head_ok) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {head_h, head_v};
          mem_wdata = head_d;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {wr_h, wr_v, wr_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear sweep walks v fastest, then h; the last write returns to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      clr_h     <= '0;
      clr_v     <= '0;
      clr_color <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state     <= CLEAR;
            clr_h     <= '0;
            clr_v     <= '0;
            clr_color <= clear_color;
          end
        end
        CLEAR: begin
          if (clr_grant) begin
            if (clr_v == V_LAST) begin
              clr_v <= '0;
              if (clr_h == H_LAST) begin
                clr_h <= '0;
                state <= IDLE;
              end else begin
                clr_h <= clr_h + 1'b1;
              end
            end else begin
              clr_v <= clr_v + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_rvalid <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      disp_rvalid <= disp_req;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter
//   Directed bench for vmem_arbiter on a 4x3 frame. A behavioural RAM sits on
//   the memory port; a reference model (write queue, sweep index, shadow
//   image) predicts every output on every cycle, and directed phases add
//   hand-computed literal expectations.

module tb_vmem_arbiter;

  localparam int DEPTH = 4;
  localparam int HP    = 4;
  localparam int VP    = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        disp_req;
  logic [9:0]  disp_h;
  logic [8:0]  disp_v;
  logic        disp_rvalid;
  logic [23:0] disp_rdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_h;
  logic [8:0]  wr_v;
  logic [23:0] wr_data;
  logic        clear_start;
  logic [23:0] clear_color;
  logic        clear_busy;
  logic [7:0]  drop_cnt;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vmem_arbiter #(.FIFO_DEPTH(DEPTH), .H_PIX(HP), .V_PIX(VP)) dut (
    .clk(clk), .resetn(resetn),
    .disp_req(disp_req), .disp_h(disp_h), .disp_v(disp_v),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_h(wr_h), .wr_v(wr_v), .wr_data(wr_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .drop_cnt(drop_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM, 1-cycle read latency.
  logic [23:0] ram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 24'h0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int h, input int v);
    return h * 512 + v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {int h; int v; logic [23:0] d;} wr_t;
  wr_t         mq[$];
  bit          m_clr = 0;
  int          m_k = 0;
  logic [23:0] m_color = '0;
  int          m_drop = 0;
  bit          m_rv = 0;
  int          m_raddr = 0;
  logic [23:0] img [int];

  function automatic logic [23:0] img_rd(input int a);
    return img.exists(a) ? img[a] : 24'h0;
  endfunction

  always @(negedge clk) begin : model
    bit   e_rdy, e_en, e_we, clr0;
    int   e_addr;
    logic [23:0] e_wd;
    wr_t  e;
    if (!resetn) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rvalid", disp_rvalid, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_drop", drop_cnt, 0);
      mq.delete();
      m_clr = 0; m_k = 0; m_drop = 0; m_rv = 0;
    end else begin
      e_rdy = (mq.size() < DEPTH);
      clr0  = m_clr;
      e_en = 0; e_we = 0; e_addr = 0; e_wd = '0;
      chk("wr_ready", wr_ready, e_rdy);
      chk("clear_busy", clear_busy, m_clr);
      chk("disp_rvalid", disp_rvalid, m_rv);
      if (m_rv) chk("disp_rdata", disp_rdata, img_rd(m_raddr));
      chk("drop_cnt", drop_cnt, m_drop);
      if (disp_req) begin
        e_en = 1; e_addr = addr_of(int'(disp_h), int'(disp_v));
      end else if (m_clr) begin
        e_en = 1; e_we = 1;
        e_addr = addr_of(m_k / VP, m_k % VP);
        e_wd = m_color;
        img[e_addr] = m_color;
        m_k++;
        if (m_k == HP * VP) m_clr = 0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.h < HP && e.v < VP) begin
          e_en = 1; e_we = 1; e_addr = addr_of(e.h, e.v); e_wd = e.d;
          img[e_addr] = e.d;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      chk("mem_en", mem_en, e_en);
      if (e_en) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      end
      if (wr_valid && e_rdy) mq.push_back('{int'(wr_h), int'(wr_v), wr_data});
      if (!clr0 && clear_start) begin
        m_clr = 1; m_k = 0; m_color = clear_color;
      end
      m_rv = disp_req;
      m_raddr = addr_of(int'(disp_h), int'(disp_v));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm, input int h, input int v, input logic [23:0] exp);
    disp_req = 1; disp_h = 10'(h); disp_v = 9'(v);
    step;
    disp_req = 0;
    @(negedge clk);
    chk({nm, "_rvalid"}, disp_rvalid, 1);
    chk(nm, disp_rdata, exp);
    step;
  endtask

  int wh[5] = '{0, 1, 2, 3, 3};
  int wv[5] = '{1, 2, 0, 1, 2};
  int ea[4] = '{1, 514, 1024, 1537};
  int acc, wes, busy_n;
  int caddr[$];

  initial begin
    resetn = 0; disp_req = 0; disp_h = '0; disp_v = '0;
    wr_valid = 0; wr_h = '0; wr_v = '0; wr_data = '0;
    clear_start = 0; clear_color = '0;
    ram[2567] = 24'hABCDEF;
    img[2567] = 24'hABCDEF;

    // Reset and idle.
    repeat (3) step;
    @(negedge clk);
    chk("in_reset_wr_ready", wr_ready, 0);
    step;
    resetn = 1;
    step;
    @(negedge clk);
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_busy", clear_busy, 0);
    chk("idle_drop", drop_cnt, 0);
    step;

    // Single scan-out read of {5,7}.
    disp_req = 1; disp_h = 10'd5; disp_v = 9'd7;
    @(negedge clk);
    chk("rd_en", mem_en, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 19'h00A07);
    step;
    disp_req = 0;
    @(negedge clk);
    chk("rd_rvalid", disp_rvalid, 1);
    chk("rd_data", disp_rdata, 24'hABCDEF);
    step;
    @(negedge clk);
    chk("rd_rvalid_drop", disp_rvalid, 0);
    step;

    // Fill the FIFO while reads hold the port.
    disp_req = 1; disp_h = '0; disp_v = '0;
    acc = 0; wes = 0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_h = 10'(wh[i]); wr_v = 9'(wv[i]); wr_data = 24'hA00001 + 24'(i);
      @(negedge clk);
      if (wr_ready) acc++;
      if (mem_en && mem_we) wes++;
      step;
    end
    wr_valid = 0; disp_req = 0;
    chk("fifo_accepted", acc, 4);
    chk("fifo_no_write_while_read", wes, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_we", mem_we, 1);
      chk("drain_addr", mem_addr, ea[i]);
      chk("drain_data", mem_wdata, 24'hA00001 + 24'(i));
      chk("drain_ready", wr_ready, (i == 0) ? 0 : 1);
      step;
    end
    @(negedge clk);
    chk("drain_done", mem_en, 0);
    step;

    // Out-of-range drops, including both exact boundaries.
    wr_valid = 1;
    wr_h = 10'd700; wr_v = 9'd10; wr_data = 24'h112233; step;
    wr_h = 10'd3;   wr_v = 9'd2;  wr_data = 24'h445566; step;
    wr_h = 10'd3;   wr_v = 9'd3;  wr_data = 24'h777777; step;
    wr_h = 10'd4;   wr_v = 9'd0;  wr_data = 24'h888888; step;
    wr_valid = 0;
    repeat (3) step;
    @(negedge clk);
    chk("drop_three", drop_cnt, 3);
    step;
    rd_chk("rd_3_2", 3, 2, 24'h445566);

    // Clear sweep with a 2-cycle read stall, a queued write and a restart attempt.
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      clear_start = (c == 0) || (c == 6);
      clear_color = (c == 0) ? 24'h0000FF : 24'h00FF00;
      disp_req = (c == 4) || (c == 5); disp_h = 10'd3; disp_v = 9'd2;
      wr_valid = (c == 6); wr_h = 10'd1; wr_v = 9'd1; wr_data = 24'hFF0000;
      @(negedge clk);
      if (clear_busy) busy_n++;
      if (clear_busy && mem_en && mem_we) caddr.push_back(int'(mem_addr));
      if (c == 15) begin
        chk("post_clear_write_addr", mem_addr, 19'h00201);
        chk("post_clear_write_data", mem_wdata, 24'hFF0000);
      end
      step;
    end
    clear_start = 0; wr_valid = 0; disp_req = 0;
    chk("clear_busy_cycles", busy_n, 14);
    chk("clear_writes", caddr.size(), 12);
    for (int i = 0; i < caddr.size() && i < 12; i++)
      chk("clear_order", caddr[i], (i / 3) * 512 + (i % 3));
    rd_chk("rd_1_1", 1, 1, 24'hFF0000);
    rd_chk("rd_0_1", 0, 1, 24'h0000FF);
    rd_chk("rd_3_2c", 3, 2, 24'h0000FF);

    // Saturation of drop_cnt.
    wr_valid = 1; wr_h = 10'd700; wr_v = 9'd0; wr_data = 24'h0;
    repeat (300) step;
    wr_valid = 0;
    repeat (4) step;
    @(negedge clk);
    chk("drop_saturated", drop_cnt, 255);
    step;

    // Clear start coinciding with a FIFO pop, then reset mid-sweep.
    wr_valid = 1; wr_h = 10'd2; wr_v = 9'd1; wr_data = 24'hC0FFEE;
    step;
    wr_valid = 0; clear_start = 1; clear_color = 24'h123456;
    @(negedge clk);
    chk("pop_with_start_addr", mem_addr, 19'h00401);
    chk("pop_with_start_busy", clear_busy, 0);
    step;
    clear_start = 0;
    @(negedge clk);
    chk("clear_began", clear_busy, 1);
    chk("clear_first_addr", mem_addr, 0);
    repeat (3) step;
    resetn = 0;
    #1;
    chk("async_rst_busy", clear_busy, 0);
    chk("async_rst_en", mem_en, 0);
    repeat (2) step;
    resetn = 1;
    step;
    @(negedge clk);
    chk("after_rst_busy", clear_busy, 0);
    chk("after_rst_ready", wr_ready, 1);
    chk("after_rst_drop", drop_cnt, 0);
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
